// File: rtl/flag_pack_pkg.sv
// Shared types, flag-to-prefix-code table and width helpers for the flag packer.
package flag_pack_pkg;

    localparam logic [4:0] CODE_F0 = 5'd1;
    localparam logic [4:0] CODE_F1 = 5'd0;
    localparam logic [4:0] CODE_F2 = 5'd2;
    localparam logic [4:0] CODE_F3 = 5'd3;
    localparam logic [4:0] CODE_F4 = 5'd7;
    localparam logic [4:0] CODE_F5 = 5'd15;
    localparam logic [4:0] CODE_F6 = 5'd31;

    localparam logic [2:0] LEN_F0 = 3'd2;
    localparam logic [2:0] LEN_F1 = 3'd2;
    localparam logic [2:0] LEN_F2 = 3'd2;
    localparam logic [2:0] LEN_F3 = 3'd3;
    localparam logic [2:0] LEN_F4 = 3'd4;
    localparam logic [2:0] LEN_F5 = 3'd5;
    localparam logic [2:0] LEN_F6 = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PACK = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Worst case: header plus every entry using the longest (5-bit) prefix.
    function automatic int calc_out_w(input int max_diff, input int pos_w, input int num_w);
        return num_w + max_diff * (5 + pos_w);
    endfunction

    // Returns {code[4:0], len[2:0]}; the illegal flag 7 falls back to flag 6.
    function automatic logic [7:0] flag_code(input logic [2:0] flag);
        logic [7:0] res;
        case (flag)
            3'd0:    res = {CODE_F0, LEN_F0};
            3'd1:    res = {CODE_F1, LEN_F1};
            3'd2:    res = {CODE_F2, LEN_F2};
            3'd3:    res = {CODE_F3, LEN_F3};
            3'd4:    res = {CODE_F4, LEN_F4};
            3'd5:    res = {CODE_F5, LEN_F5};
            default: res = {CODE_F6, LEN_F6};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/flag_pack_core_flag_code_lut.sv
// Combinational lookup from a 3-bit diff flag to its prefix code and length.
module flag_code_lut
    import flag_pack_pkg::*;
(
    input  logic [2:0] flag,
    output logic [4:0] code,
    output logic [2:0] len,
    output logic       illegal
);

    always_comb begin
        {code, len} = flag_code(flag);
        illegal     = (flag == 3'd7);
    end

endmodule

// File: rtl/flag_pack_core.sv
// Serially packs a tile diff descriptor into an LSB-first {count, records} bitstream
// and holds the result until the downstream packer accepts it.
module flag_pack_core
    import flag_pack_pkg::*;
#(
    parameter int MAX_DIFF = 7,
    parameter int POS_W    = 6,
    parameter int NUM_W    = 3,
    parameter int OUT_W    = calc_out_w(MAX_DIFF, POS_W, NUM_W),
    parameter int BYTE_W   = $clog2(OUT_W / 8 + 2),
    localparam int BS_W    = $clog2(OUT_W + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_valid,
    output logic                      i_ready,
    input  logic [NUM_W-1:0]          diff_num,
    input  logic [3*MAX_DIFF-1:0]     diff_flag,
    input  logic [POS_W*MAX_DIFF-1:0] diff_position,
    output logic                      o_valid,
    input  logic                      o_ready,
    output logic [OUT_W-1:0]          o_data,
    output logic [BS_W-1:0]           o_bitsize,
    output logic [BYTE_W-1:0]         o_bytesize,
    output logic                      o_err
);

    localparam logic [NUM_W-1:0] MAX_N = NUM_W'(MAX_DIFF);
    localparam int               REC_W = 5 + POS_W;

    state_e                    state_q, state_d;
    logic [NUM_W-1:0]          n_q, n_d;
    logic [NUM_W-1:0]          idx_q, idx_d;
    logic [3*MAX_DIFF-1:0]     flag_q, flag_d;
    logic [POS_W*MAX_DIFF-1:0] pos_q, pos_d;
    logic [OUT_W-1:0]          data_q, data_d;
    logic [BS_W-1:0]           bitsize_q, bitsize_d;
    logic [BYTE_W-1:0]         bytesize_q, bytesize_d;
    logic                      err_q, err_d;
    logic                      valid_q, valid_d;
    logic                      ready_q, ready_d;

    logic [2:0]       flag_arr [MAX_DIFF];
    logic [POS_W-1:0] pos_arr  [MAX_DIFF];

    genvar gi;
    generate
        for (gi = 0; gi < MAX_DIFF; gi++) begin : g_unpack
            assign flag_arr[gi] = flag_q[3*gi +: 3];
            assign pos_arr[gi]  = pos_q[POS_W*gi +: POS_W];
        end
    endgenerate

    logic [2:0]       cur_flag;
    logic [POS_W-1:0] cur_pos;
    logic [4:0]       cur_code;
    logic [2:0]       cur_len;
    logic             cur_illegal;

    assign cur_flag = flag_arr[idx_q];
    assign cur_pos  = pos_arr[idx_q];

    flag_code_lut u_lut (
        .flag    (cur_flag),
        .code    (cur_code),
        .len     (cur_len),
        .illegal (cur_illegal)
    );

    logic [OUT_W-1:0] rec_ext;
    logic [NUM_W-1:0] n_clamp;
    logic [BS_W-1:0]  byte_calc;

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        idx_d      = idx_q;
        flag_d     = flag_q;
        pos_d      = pos_q;
        data_d     = data_q;
        bitsize_d  = bitsize_q;
        bytesize_d = bytesize_q;
        err_d      = err_q;
        valid_d    = valid_q;
        ready_d    = ready_q;

        // Prefix code sits directly above the position; unused code bits are zero.
        rec_ext              = '0;
        rec_ext[REC_W-1:0]   = {cur_code, cur_pos};
        n_clamp              = (diff_num > MAX_N) ? MAX_N : diff_num;

        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    n_d                = n_clamp;
                    idx_d              = '0;
                    flag_d             = diff_flag;
                    pos_d              = diff_position;
                    data_d             = '0;
                    data_d[NUM_W-1:0]  = n_clamp;
                    bitsize_d          = BS_W'(NUM_W);
                    err_d              = (diff_num > MAX_N);
                    ready_d            = 1'b0;
                    if (n_clamp != '0) begin
                        state_d = ST_PACK;
                    end else begin
                        state_d = ST_DONE;
                        valid_d = 1'b1;
                    end
                end
            end
            ST_PACK: begin
                data_d    = data_q | (rec_ext << bitsize_q);
                bitsize_d = bitsize_q + BS_W'(cur_len) + BS_W'(POS_W);
                err_d     = err_q | cur_illegal;
                idx_d     = idx_q + 1'b1;
                if (idx_q == n_q - 1'b1) begin
                    state_d = ST_DONE;
                    valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (o_ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                ready_d = 1'b1;
            end
        endcase

        byte_calc = (bitsize_d >> 3) + BS_W'(|bitsize_d[2:0]);
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            bytesize_d = BYTE_W'(byte_calc);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            idx_q      <= '0;
            flag_q     <= '0;
            pos_q      <= '0;
            data_q     <= '0;
            bitsize_q  <= '0;
            bytesize_q <= '0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            flag_q     <= flag_d;
            pos_q      <= pos_d;
            data_q     <= data_d;
            bitsize_q  <= bitsize_d;
            bytesize_q <= bytesize_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
        end
    end

    assign i_ready    = ready_q;
    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_bitsize  = bitsize_q;
    assign o_bytesize = bytesize_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_flag_pack_core.sv
// Directed, table-driven bench for flag_pack_core at default and clamped (MAX_DIFF=5) sizes.
module tb_flag_pack_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        o_ready = 1'b1;

    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [2:0]  diff_num = '0;
    logic [20:0] diff_flag = '0;
    logic [41:0] diff_position = '0;
    logic        o_valid;
    logic [79:0] o_data;
    logic [6:0]  o_bitsize;
    logic [3:0]  o_bytesize;
    logic        o_err;

    logic        i_valid5 = 1'b0;
    logic        i_ready5;
    logic [2:0]  diff_num5 = '0;
    logic [14:0] diff_flag5 = '0;
    logic [29:0] diff_position5 = '0;
    logic        o_valid5;
    logic [57:0] o_data5;
    logic [5:0]  o_bitsize5;
    logic [3:0]  o_bytesize5;
    logic        o_err5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flag_pack_core dut (
        .clk (clk), .rst_n (rst_n),
        .i_valid (i_valid), .i_ready (i_ready),
        .diff_num (diff_num), .diff_flag (diff_flag), .diff_position (diff_position),
        .o_valid (o_valid), .o_ready (o_ready),
        .o_data (o_data), .o_bitsize (o_bitsize), .o_bytesize (o_bytesize), .o_err (o_err)
    );

    flag_pack_core #(.MAX_DIFF(5), .POS_W(6), .NUM_W(3)) dut5 (
        .clk (clk), .rst_n (rst_n),
        .i_valid (i_valid5), .i_ready (i_ready5),
        .diff_num (diff_num5), .diff_flag (diff_flag5), .diff_position (diff_position5),
        .o_valid (o_valid5), .o_ready (o_ready),
        .o_data (o_data5), .o_bitsize (o_bitsize5), .o_bytesize (o_bytesize5), .o_err (o_err5)
    );

    typedef struct packed {
        logic [2:0]  num;
        logic [20:0] flag;
        logic [41:0] pos;
        logic [79:0] data;
        logic [6:0]  bs;
        logic [3:0]  by;
        logic        err;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!i_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("i_ready_timeout", {79'd0, i_ready}, 80'd1);
    endtask

    // Accept on the next posedge; returns cycles (negedges) until o_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 0;
        @(posedge clk);
        do begin
            @(negedge clk);
            i_valid = 1'b0;
            lat++;
        end while (!o_valid && lat < 40);
    endtask

    task automatic run_vec(input int k);
        int lat;
        vec_t v;
        v = vecs[k];
        wait_ready();
        diff_num      = v.num;
        diff_flag     = v.flag;
        diff_position = v.pos;
        i_valid       = 1'b1;
        wait_valid(lat);
        check($sformatf("v%0d_latency", k), 80'(lat), 80'(v.num + 1));
        check($sformatf("v%0d_data", k), o_data, v.data);
        check($sformatf("v%0d_bitsize", k), 80'(o_bitsize), 80'(v.bs));
        check($sformatf("v%0d_bytesize", k), 80'(o_bytesize), 80'(v.by));
        check($sformatf("v%0d_err", k), 80'(o_err), 80'(v.err));
        check($sformatf("v%0d_iready_busy", k), 80'(i_ready), 80'd0);
        $display("vec %0d: n=%0d data=%h bits=%0d bytes=%0d err=%0d lat=%0d",
                 k, v.num, o_data, o_bitsize, o_bytesize, o_err, lat);
        @(negedge clk);
        check($sformatf("v%0d_consumed", k), 80'(o_valid), 80'd0);
    endtask

    initial begin
        int lat;

        vecs[0] = '{num: 3'd0, flag: '0, pos: '0,
                    data: 80'h0, bs: 7'd3, by: 4'd1, err: 1'b0};
        vecs[1] = '{num: 3'd2, flag: {{5{3'd0}}, 3'd6, 3'd0}, pos: {{5{6'd0}}, 6'd63, 6'd5},
                    data: 80'h3FFA2A, bs: 7'd22, by: 4'd3, err: 1'b0};
        vecs[2] = '{num: 3'd7, flag: {7{3'd6}}, pos: {7{6'd63}},
                    data: {80{1'b1}}, bs: 7'd80, by: 4'd10, err: 1'b0};
        vecs[3] = '{num: 3'd1, flag: {{6{3'd0}}, 3'd7}, pos: '0,
                    data: 80'h3E01, bs: 7'd14, by: 4'd2, err: 1'b1};
        vecs[4] = '{num: 3'd1, flag: {{6{3'd0}}, 3'd1}, pos: '0,
                    data: 80'h1, bs: 7'd11, by: 4'd2, err: 1'b0};
        vecs[5] = '{num: 3'd1, flag: {{6{3'd7}}, 3'd3}, pos: {{6{6'd63}}, 6'd10},
                    data: 80'h651, bs: 7'd12, by: 4'd2, err: 1'b0};
        vecs[6] = '{num: 3'd3, flag: {{4{3'd0}}, 3'd2, 3'd5, 3'd4},
                    pos: {{4{6'd0}}, 6'd3, 6'd2, 6'd1},
                    data: 80'h83784E0B, bs: 7'd32, by: 4'd4, err: 1'b0};

        repeat (2) @(negedge clk);
        check("rst_o_valid", 80'(o_valid), 80'd0);
        check("rst_o_data", o_data, 80'd0);
        check("rst_o_bitsize", 80'(o_bitsize), 80'd0);
        check("rst_o_bytesize", 80'(o_bytesize), 80'd0);
        check("rst_o_err", 80'(o_err), 80'd0);
        check("rst_i_ready", 80'(i_ready), 80'd1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 7; k++) run_vec(k);

        // Clamp: diff_num 7 on a 5-entry instance.
        diff_num5      = 3'd7;
        diff_flag5     = {5{3'd1}};
        diff_position5 = '0;
        i_valid5       = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            i_valid5 = 1'b0;
            lat++;
        end while (!o_valid5 && lat < 40);
        check("clamp_latency", 80'(lat), 80'd6);
        check("clamp_data", 80'(o_data5), 80'd5);
        check("clamp_bitsize", 80'(o_bitsize5), 80'd43);
        check("clamp_bytesize", 80'(o_bytesize5), 80'd6);
        check("clamp_err", 80'(o_err5), 80'd1);
        $display("clamp: data=%h bits=%0d bytes=%0d err=%0d lat=%0d",
                 o_data5, o_bitsize5, o_bytesize5, o_err5, lat);
        @(negedge clk);

        // Backpressure: result must hold while o_ready is low and i_valid pulses.
        o_ready = 1'b0;
        wait_ready();
        diff_num      = vecs[1].num;
        diff_flag     = vecs[1].flag;
        diff_position = vecs[1].pos;
        i_valid       = 1'b1;
        wait_valid(lat);
        check("bp_latency", 80'(lat), 80'd3);
        for (int c = 0; c < 5; c++) begin
            i_valid  = c[0];
            diff_num = 3'd4;
            @(negedge clk);
            check($sformatf("bp_hold%0d_valid", c), 80'(o_valid), 80'd1);
            check($sformatf("bp_hold%0d_data", c), o_data, 80'h3FFA2A);
            check($sformatf("bp_hold%0d_bits", c), 80'(o_bitsize), 80'd22);
            check($sformatf("bp_hold%0d_bytes", c), 80'(o_bytesize), 80'd3);
            check($sformatf("bp_hold%0d_iready", c), 80'(i_ready), 80'd0);
            $display("hold %0d: valid=%0d data=%h i_ready=%0d", c, o_valid, o_data, i_ready);
        end
        // Release with i_valid also high in DONE: output taken, descriptor not.
        i_valid  = 1'b1;
        diff_num = 3'd5;
        o_ready  = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 80'(o_valid), 80'd0);
        check("bp_release_iready", 80'(i_ready), 80'd1);
        diff_num      = 3'd0;
        diff_flag     = '0;
        diff_position = '0;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        check("bp_next_valid", 80'(o_valid), 80'd1);
        check("bp_next_bitsize", 80'(o_bitsize), 80'd3);
        check("bp_next_data", o_data, 80'd0);
        $display("post-release: valid=%0d bits=%0d data=%h", o_valid, o_bitsize, o_data);
        @(negedge clk);

        // Asynchronous reset in the middle of PACK discards the partial packet.
        wait_ready();
        diff_num      = vecs[2].num;
        diff_flag     = vecs[2].flag;
        diff_position = vecs[2].pos;
        i_valid       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_o_valid", 80'(o_valid), 80'd0);
        check("midrst_o_data", o_data, 80'd0);
        check("midrst_o_bitsize", 80'(o_bitsize), 80'd0);
        check("midrst_o_bytesize", 80'(o_bytesize), 80'd0);
        check("midrst_o_err", 80'(o_err), 80'd0);
        check("midrst_i_ready", 80'(i_ready), 80'd1);
        $display("mid-PACK reset: valid=%0d data=%h i_ready=%0d", o_valid, o_data, i_ready);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flag_pack_core.md
# flag_pack_core

Parametrised successor to the fixed 7-entry flag compressor in the RGB lossless compression path. It accepts one tile's diff descriptor (count, per-entry flag, per-entry position) through a valid/ready handshake. It serially packs a count header plus one variable-length {prefix code, position} record per entry into an LSB-first bitstream, then reports the packed data and byte size. Its output holds until the downstream packer accepts it. It sits between the tile diff detector and the byte-stream assembler.

## Interface
Parameters:
- MAX_DIFF, 7: maximum entries per tile.
- POS_W, 6: position field width.
- NUM_W, 3: header count width; requires MAX_DIFF < 2**NUM_W.
- OUT_W, NUM_W + MAX_DIFF*(5+POS_W): packed data width (80 at defaults).
- BYTE_W, $clog2(OUT_W/8+2): byte-size width.

Ports:
- clk  in  1  clock. One clock domain; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  descriptor valid.
- i_ready  out  1  block idle, can accept.
- diff_num  in  NUM_W  entry count.
- diff_flag  in  3*MAX_DIFF  flag of entry k at [3k+2:3k].
- diff_position  in  POS_W*MAX_DIFF  position of entry k at [POS_W*k+POS_W-1:POS_W*k].
- o_valid  out  1  packed result valid.
- o_ready  in  1  downstream accepts result.
- o_data  out  OUT_W  packed bitstream; unused upper bits are zero.
- o_bitsize  out  $clog2(OUT_W+1)  valid bit count.
- o_bytesize  out  BYTE_W  ceil(o_bitsize/8).
- o_err  out  1  this packet had a clamped count or an illegal flag.

## Operation
Flag to {code, length} mapping, with the code placed above the position:
- 0 → 1/2
- 1 → 0/2
- 2 → 2/2
- 3 → 3/3
- 4 → 7/4
- 5 → 15/5
- 6 → 31/5
- 7 is illegal: encode as flag 6 and set the error.

Record k is {code, pos_k}, length + POS_W bits, OR-ed into o_data at the current bitsize.

FSM states:
- IDLE: i_ready=1. On i_valid, capture inputs.
  - Set n = min(diff_num, MAX_DIFF).
  - o_data ← n, bitsize ← NUM_W, idx ← 0.
  - err ← (diff_num > MAX_DIFF).
  - Go to PACK if n>0, else DONE.
- PACK: each cycle append record idx, bitsize += len+POS_W, err |= (flag==7), idx++. When idx==n-1, go to DONE.
- DONE: o_valid=1. On o_ready, go to IDLE.

Output rules:
- o_bytesize is registered on entry to DONE from the final bitsize.
- Records with k ≥ n are ignored regardless of their content.
- o_data, o_bitsize, o_bytesize and o_err are stable while o_valid && !o_ready.
- o_data is cleared at capture. No stale bits survive from the previous packet.

## Timing
- Reset values: state IDLE; o_valid, o_data, o_bitsize, o_bytesize, o_err all 0. i_ready=1 out of reset.
- Latency: with acceptance at edge E0, o_valid is high in the cycle after edge E0+n. n=0 gives o_valid 1 cycle after acceptance; n=MAX_DIFF gives MAX_DIFF+1 cycles.
- Throughput: at most one packet per n+2 cycles.
  - i_ready is low from the cycle after acceptance until the cycle after o_valid&&o_ready.
  - i_valid is ignored when i_ready=0. Inputs need only be valid in the accept cycle.
- o_valid, o_ready and i_valid may all be high in the same DONE cycle. The output is accepted, and the new descriptor is not taken until IDLE.
- Reset mid-PACK or mid-DONE: outputs return to reset values on the next clk-independent assertion. The partial packet is discarded.
- Width: the maximum bitsize is exactly OUT_W, with no overflow. The bytesize computation is bitsize[..:3] + |bitsize[2:0].

## Structure
- flag_pack_pkg holds:
  - the flag code and length constants;
  - the function flag_code(flag) → {code[4:0], len[2:0]};
  - the function for OUT_W;
  - the FSM state enum.
- One combinational sub-module, flag_code_lut: maps flag to code, length and illegal.
- Everything else is in flag_pack_core.

## Test plan
- n=0, defaults: diff_num=0 → o_data=0, bitsize 3, bytesize 1, o_valid 1 cycle after accept, err=0.
- n=2, flag0=0/pos0=5, flag1=6/pos1=63 → o_data=0x3FFA2A, bitsize 22, bytesize 3, o_valid 3 cycles after accept.
- n=7, all flag 6, pos 63 → o_data all 80 bits ones, bitsize 80, bytesize 10.
- diff_num=7 with MAX_DIFF=5 and NUM_W=3, all flag 1, pos 0:
  - n clamps to 5.
  - o_data = 5 in the header, bitsize 43, bytesize 6, err=1.
- Flag 7 in entry 0 → encoded as flag 6 and err=1. The next clean packet reports err=0 and has no stale upper bits.
- Backpressure: hold o_ready=0 for 5 cycles while pulsing i_valid.
  - Outputs stay stable and i_ready stays 0.
  - After o_ready, the next descriptor is accepted one cycle later.
  - Assert rst_n low mid-PACK: all outputs go to 0 immediately.
